// File: rtl/alu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_issue
// Description : RV32I decode/issue stage. Reads rs1/rs2 from a 32x32 register
//               file with writeback bypass, decodes imm/opcode/ALU field and
//               presents one registered operand bundle under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_opcode,
  output logic [3:0]      out_field,
  output logic [4:0]      out_rd_addr,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] C_OP   = 7'b0110011;
  localparam logic [6:0] C_OP_I = 7'b0010011;
  localparam logic [6:0] C_OP_S = 7'b0100011;
  localparam logic [6:0] C_OP_B = 7'b1100011;
  localparam logic [6:0] C_OP_U = 7'b0110111;
  localparam logic [6:0] C_OP_J = 7'b1101111;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_valid;
  logic [XLEN-1:0] r_rs1, r_rs2, r_imm;
  logic [6:0]      r_opcode;
  logic [3:0]      r_field;
  logic [4:0]      r_rd_addr;
  logic            r_illegal;
  // Source addresses of the held operands; 0 means "not a register read".
  logic [4:0]      r_rs1_src, r_rs2_src;

  logic [2:0]      w_f3;
  logic [3:0]      w_field;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_rd;
  logic            w_illegal;
  logic            w_use_rs1, w_use_rs2;
  logic [4:0]      w_rs1_src, w_rs2_src;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic            w_accept;
  logic            w_wb_live;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_wb_live = wb_en && (wb_addr != 5'd0);
  assign w_f3      = in_inst[14:12];

  // Instruction decode: immediate, ALU field, destination and operand usage.
  always_comb begin
    w_field   = 4'b0000;
    w_imm     = '0;
    w_rd      = 5'd0;
    w_illegal = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b1;
    case (in_inst[6:0])
      C_OP: begin
        w_field = {in_inst[30], w_f3};
        w_rd    = in_inst[11:7];
      end
      C_OP_I: begin
        // Only SRAI/SRLI carry inst[30]; ADDI must never turn into SUB.
        w_field = {(w_f3 == 3'b101) && in_inst[30], w_f3};
        w_rd    = in_inst[11:7];
        if (w_f3 == 3'b001 || w_f3 == 3'b101)
          w_imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};
        else
          w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      end
      C_OP_S: begin
        w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      C_OP_B: begin
        w_field = 4'b1000;
        w_imm   = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      C_OP_U: begin
        w_use_rs1 = 1'b0;
        w_rd      = in_inst[11:7];
        w_imm     = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
      end
      C_OP_J: begin
        w_use_rs1 = 1'b0;
        w_rd      = in_inst[11:7];
        w_imm     = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
      end
      default: begin
        w_illegal = 1'b1;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
    endcase
  end

  // Operand read with same-cycle writeback bypass; x0 and unused operands read 0.
  always_comb begin
    w_rs1_src = w_use_rs1 ? in_inst[19:15] : 5'd0;
    w_rs2_src = w_use_rs2 ? in_inst[24:20] : 5'd0;
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1_src != 5'd0)
      w_rs1_val = (w_wb_live && wb_addr == w_rs1_src) ? wb_data : r_regs[w_rs1_src];
    if (w_rs2_src != 5'd0)
      w_rs2_val = (w_wb_live && wb_addr == w_rs2_src) ? wb_data : r_regs[w_rs2_src];
  end

  // Register file, output bundle register and held-operand refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_valid   <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_opcode  <= 7'd0;
      r_field   <= 4'd0;
      r_rd_addr <= 5'd0;
      r_illegal <= 1'b0;
      r_rs1_src <= 5'd0;
      r_rs2_src <= 5'd0;
    end else begin
      if (w_wb_live) r_regs[wb_addr] <= wb_data;
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_rs1     <= w_rs1_val;
        r_rs2     <= w_rs2_val;
        r_imm     <= w_imm;
        r_opcode  <= in_inst[6:0];
        r_field   <= w_field;
        r_rd_addr <= w_rd;
        r_illegal <= w_illegal;
        r_rs1_src <= w_rs1_src;
        r_rs2_src <= w_rs2_src;
      end else if (r_valid) begin
        if (out_ready) r_valid <= 1'b0;
        if (w_wb_live && wb_addr == r_rs1_src) r_rs1 <= wb_data;
        if (w_wb_live && wb_addr == r_rs2_src) r_rs2 <= wb_data;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_imm     = r_imm;
  assign out_opcode  = r_opcode;
  assign out_field   = r_field;
  assign out_rd_addr = r_rd_addr;
  assign out_illegal = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Decode/issue stage that produces every ALU input: rs1, rs2, imm, opcode and the 4-bit field {funct7[5], funct3}.
- Accepts one 32-bit RV32I instruction per handshake and reads operands from an internal 32x32 register file.
- Presents the decoded operand bundle in a single registered output stage, with valid/ready flow control.
- Closes the loop with the ALU: the writeback port returns ALU rd results into the register file and bypasses them into operands.

Parameters:
- XLEN, 32, operand/register width.
- NREGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  RV32I instruction word.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU/consumer accepts the bundle.
- out_rs1  out  XLEN  operand 1.
- out_rs2  out  XLEN  operand 2.
- out_imm  out  XLEN  decoded immediate.
- out_opcode  out  7  inst[6:0].
- out_field  out  4  ALU operation select.
- out_rd_addr  out  5  destination register.
- out_illegal  out  1  unsupported opcode flag.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback register.
- wb_data  in  XLEN  writeback value (ALU rd).

Behaviour:
- Reset: all out_* are 0, out_valid=0, and all registers are cleared to 0. Reset mid-transfer drops the held bundle; no partial state survives.
- in_ready = !out_valid || out_ready (combinational).
- Transfer occurs when in_valid && in_ready. The bundle is registered on that edge, so latency is 1 cycle.
- A held bundle stays stable while out_valid && !out_ready.
- A consume without a new accept clears out_valid.
- Opcode decode:
  - OP (0110011): field = {inst[30], inst[14:12]}; imm = 0.
  - OP_I (0010011): field bit3 = inst[30] only when funct3 = 101, otherwise 0 (ADDI never becomes SUB).
    - Shifts (funct3 001/101): imm = zero-extended inst[24:20].
    - Otherwise: imm = sign-extended inst[31:20].
  - OP_S (0100011): field = 0000; imm = sext{inst[31:25], inst[11:7]}.
  - OP_B (1100011): field = 1000 (SUB compare); imm = sext{inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - OP_U (0110111): field = 0000; rs1 forced to 0; imm = {inst[31:12], 12'b0}.
  - OP_J (1101111): field = 0000; rs1 = 0; imm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: out_illegal = 1, operands/imm/field = 0, bundle still issued.
- out_rd_addr = inst[11:7] for OP/OP_I/OP_U/OP_J and 0 for OP_S/OP_B.
- Register file write: on each edge with wb_en && wb_addr != 0. Writes to x0 are ignored and x0 always reads 0.
- Bypass at accept: if wb_en && wb_addr != 0 && wb_addr == source address in the same cycle, the operand takes wb_data, not the stale register value.
- Hold update: while a bundle is held, a writeback matching its rs1/rs2 source address (nonzero, and not a forced-zero operand) overwrites the held operand on that edge. The stored source addresses are tracked internally.
- Simultaneous consume+accept: the new bundle replaces the old in the same edge; out_valid stays 1 and there is no bubble.
- Simultaneous writeback and accept of an instruction whose rd equals wb_addr: no interaction; the stage does no scoreboard stalling.

Test Plan:
- Reset, then x1=5, x2=7 via wb. Issue 0x002081B3 (ADD x3,x1,x2) with out_ready=1 → next cycle out_valid=1, rs1=5, rs2=7, field=0000, opcode=0x33, rd_addr=3.
- Issue 0x40335293 (SRAI x5,x6,3) with x6=0x80000000 → field=1101, imm=3, rs1=0x80000000.
- Issue 0xFE20AE23 (SW x2,-4(x1)) → imm=0xFFFFFFFC, field=0000, rd_addr=0; then 0x123453B7 (LUI) → imm=0x12345000, rs1=0.
- Hold out_ready=0 after issuing ADD x3,x1,x2, then wb x2=0x99 → in_ready=0, out_rs2 becomes 0x99, other outputs stable. Raise out_ready → consumed, out_valid drops.
- Same-cycle wb x1=0xAA with accept of ADD x3,x1,x2 → out_rs1=0xAA; wb to x0 with 0xFFFF → later read of x0 gives 0.
- Back-to-back accepts with out_ready=1 for 4 cycles → 4 bundles, no bubbles. Opcode 0x7F → out_illegal=1. Assert rst while held → out_valid=0 next cycle.
